rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- 16-entry reorder buffer; the allocating and committing end of the register-rename interface that RegFile consumes.
- On issue it hands out a 4-bit ROB tag and drives the rename write (rd_in_*) toward RegFile.
- Collects results from the common data bus (CDB), answers operand queries by tag, and retires in program order, driving the commit write (rd_out_*).
- A committed mispredicted branch flushes the buffer and redirects fetch.

Parameters:
- DEPTH, 16, number of entries; tag width fixed at 4, so DEPTH must be 16.
- XLEN, 32, data and PC width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; when low, no state changes and all *_flag/fire outputs are 0
- issue_valid  in  1  dispatch presents an instruction
- issue_has_rd  in  1  instruction writes a destination register
- issue_rd  in  5  destination register index
- issue_ready  out  1  space available; registered: (count != 16)
- issue_tag  out  4  tag assigned = tail pointer
- rd_in_flag  out  1  rename write to RegFile
- rd_in_a  out  5  = issue_rd
- rd_in_rob  out  4  = tail pointer
- cdb_valid  in  1  execution result broadcast
- cdb_rob  in  4  tag of the result
- cdb_val  in  32  result value
- cdb_mispred  in  1  entry is a mispredicted branch
- cdb_target  in  32  correct PC for a mispredict
- q1_rob, q2_rob  in  4 each  operand tags to look up
- q1_ready, q2_ready  out  1 each  tagged entry is valid and has its result
- q1_val, q2_val  out  32 each  entry value; 0 when not ready
- rd_out_flag  out  1  commit write to RegFile
- rd_out_a  out  5  destination register of the committing entry
- rd_out_rob  out  4  = head pointer
- rd_out_val  out  32  value of the committing entry
- flush  out  1  pulse: commit of a mispredicted entry
- flush_pc  out  32  cdb_target stored in that entry

Behaviour:
- Per-entry state: busy, done, has_rd, rd[4:0], val[31:0], mispred, target[31:0]. Pointers: head[3:0], tail[3:0], count[4:0].
- Reset (async, rst_n=0): head=tail=count=0; all busy/done/mispred cleared; issue_ready=1; every flag and fire output 0. Reset may arrive mid-operation; the buffer empties immediately.
- Issue fire: issue_fire = rdy & issue_valid & issue_ready & !flush.
  - Next edge: entry[tail] gets busy=1, done=0, mispred=0, has_rd and rd loaded; tail increments mod 16.
  - rd_in_flag = issue_fire & issue_has_rd, combinational in the same cycle, so RegFile renames on the same edge.
- CDB write: when rdy & cdb_valid & busy[cdb_rob] & !flush, next edge sets done=1 and loads val, mispred and target. A CDB write to a non-busy entry is ignored.
- Commit fire: commit_fire = rdy & busy[head] & done[head], combinational.
  - rd_out_flag = commit_fire & has_rd[head].
  - rd_out_a, rd_out_val and rd_out_rob are always driven from the head entry.
  - Next edge: busy[head] cleared; head increments mod 16.
  - Commit rate is at most one entry per cycle.
- count update:
  - +1 on issue only; -1 on commit only; unchanged when both fire.
  - issue_ready is recomputed from the registered count, so it stays low for the cycle in which a full buffer commits.
- Flush: flush = commit_fire & mispred[head]; flush_pc = target[head].
  - The commit write still occurs that cycle (rd_out_flag per has_rd), so a JALR-style rd is retired.
  - Next edge: head=tail=count=0 and every busy/done bit cleared.
  - A same-cycle issue and CDB write are dropped (rd_in_flag is held 0).
- Wrap-around: pointers wrap 15->0. Full means count==16; empty means count==0. Commit is impossible when empty because busy[head]=0.
- Query: qN_ready = busy[qN_rob] & done[qN_rob]; qN_val = val[qN_rob] when ready, else 0. A query returns the registered state (the state before the current edge).

Optional Feature:
- Macro: ROB_CDB_FWD_EN.
- When defined:
  - Queries forward a same-cycle CDB result: if cdb_valid & cdb_rob==qN_rob & busy[qN_rob], then qN_ready=1 and qN_val=cdb_val.
  - Commit also fires in the cycle the head entry's result arrives on the CDB, using cdb_val and cdb_mispred directly, which saves one cycle.
- When undefined: queries and commit see only registered done/val, so the result-to-commit latency is 1 cycle longer.

Test Plan:
- Reset, then issue rd=5 -> issue_tag=0, rd_in_flag=1, rd_in_a=5, rd_in_rob=0. A CDB write of tag 0 with val 0x1234 is followed next cycle by rd_out_flag=1, rd_out_a=5, rd_out_val=0x1234, rd_out_rob=0.
- Issue 3 entries, then CDB writes to tags 2 and 1 before tag 0 -> no commit until tag 0 completes, then commits on consecutive cycles in order 0,1,2.
- Issue 16 entries with no commit -> issue_ready=0 after the 16th and a 17th issue is not accepted. Complete tag 0 -> one commit, issue_ready=1 the following cycle, and the next issue_tag=0 (wrap).
- Issue tag 0 (branch, no rd) and tag 1 (rd=7), then CDB tag 0 with mispred=1 and target 0x80 -> flush=1 with flush_pc=0x80 on commit, and next cycle count=0 with issue_tag=0.
- Hold rdy=0 while issue_valid=1 and cdb_valid=1 -> no tag consumed, done bits unchanged, rd_in_flag=0 and rd_out_flag=0.
- With ROB_CDB_FWD_EN: q1_rob=3 while the CDB broadcasts tag 3 with val 0xAB -> q1_ready=1 and q1_val=0xAB in the same cycle. Without the macro: q1_ready=0 that cycle and 1 the next.

Source files
------------

// File: rtl/rob_commit_if.sv
// rob_commit_if: issue, rename, CDB, operand-query and commit signals of the reorder buffer
interface rob_commit_if #(parameter int XLEN = 32);
   logic            rdy;
   logic            issue_valid;
   logic            issue_has_rd;
   logic [4:0]      issue_rd;
   logic            issue_ready;
   logic [3:0]      issue_tag;
   logic            rd_in_flag;
   logic [4:0]      rd_in_a;
   logic [3:0]      rd_in_rob;
   logic            cdb_valid;
   logic [3:0]      cdb_rob;
   logic [XLEN-1:0] cdb_val;
   logic            cdb_mispred;
   logic [XLEN-1:0] cdb_target;
   logic [3:0]      q1_rob;
   logic [3:0]      q2_rob;
   logic            q1_ready;
   logic            q2_ready;
   logic [XLEN-1:0] q1_val;
   logic [XLEN-1:0] q2_val;
   logic            rd_out_flag;
   logic [4:0]      rd_out_a;
   logic [3:0]      rd_out_rob;
   logic [XLEN-1:0] rd_out_val;
   logic            flush;
   logic [XLEN-1:0] flush_pc;
   modport slave (
      input  rdy, issue_valid, issue_has_rd, issue_rd, cdb_valid, cdb_rob, cdb_val, cdb_mispred,
             cdb_target, q1_rob, q2_rob,
      output issue_ready, issue_tag, rd_in_flag, rd_in_a, rd_in_rob, q1_ready, q2_ready, q1_val,
             q2_val, rd_out_flag, rd_out_a, rd_out_rob, rd_out_val, flush, flush_pc
   );
   modport master (
      output rdy, issue_valid, issue_has_rd, issue_rd, cdb_valid, cdb_rob, cdb_val, cdb_mispred,
             cdb_target, q1_rob, q2_rob,
      input  issue_ready, issue_tag, rd_in_flag, rd_in_a, rd_in_rob, q1_ready, q2_ready, q1_val,
             q2_val, rd_out_flag, rd_out_a, rd_out_rob, rd_out_val, flush, flush_pc
   );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: 16-entry reorder buffer (issue, CDB completion, in-order commit, mispredict flush); define ROB_CDB_FWD_EN to forward same-cycle CDB results
module rob_commit #(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32
) (
   input logic        clk,
   input logic        rst_n,
   rob_commit_if.slave rob
);
   logic [DEPTH-1:0] busy_q, busy_d, done_q, done_d, mis_q, mis_d, has_rd_q, has_rd_d;
   logic [4:0]       rd_q [DEPTH];
   logic [4:0]       rd_d [DEPTH];
   logic [XLEN-1:0]  val_q [DEPTH];
   logic [XLEN-1:0]  val_d [DEPTH];
   logic [XLEN-1:0]  tgt_q [DEPTH];
   logic [XLEN-1:0]  tgt_d [DEPTH];
   logic [3:0]       head_q, head_d, tail_q, tail_d;
   logic [4:0]       count_q, count_d;
   logic             en, issue_fire, commit_fire, cdb_wr, head_hit, q1_fwd, q2_fwd, q1_hit, q2_hit;
   logic             head_mis;
   logic [XLEN-1:0]  head_val, head_tgt;
   // outputs are gated by rst_n so no flag can pulse while reset is held
   assign en = rob.rdy & rst_n;
`ifdef ROB_CDB_FWD_EN
   assign head_hit = rob.cdb_valid & (rob.cdb_rob == head_q);
   assign q1_fwd   = rob.cdb_valid & (rob.cdb_rob == rob.q1_rob) & busy_q[rob.q1_rob];
   assign q2_fwd   = rob.cdb_valid & (rob.cdb_rob == rob.q2_rob) & busy_q[rob.q2_rob];
`else
   assign head_hit = 1'b0;
   assign q1_fwd   = 1'b0;
   assign q2_fwd   = 1'b0;
`endif
   assign head_val    = done_q[head_q] ? val_q[head_q] : rob.cdb_val;
   assign head_mis    = done_q[head_q] ? mis_q[head_q] : rob.cdb_mispred;
   assign head_tgt    = done_q[head_q] ? tgt_q[head_q] : rob.cdb_target;
   assign commit_fire = en & busy_q[head_q] & (done_q[head_q] | head_hit);
   assign rob.flush    = commit_fire & head_mis;
   assign rob.flush_pc = head_tgt;
   assign rob.issue_ready = count_q != 5'(DEPTH);
   assign issue_fire      = en & rob.issue_valid & rob.issue_ready & ~rob.flush;
   assign rob.issue_tag   = tail_q;
   assign rob.rd_in_flag  = issue_fire & rob.issue_has_rd;
   assign rob.rd_in_a     = rob.issue_rd;
   assign rob.rd_in_rob   = tail_q;
   assign cdb_wr          = en & rob.cdb_valid & busy_q[rob.cdb_rob] & ~rob.flush;
   assign rob.rd_out_flag = commit_fire & has_rd_q[head_q];
   assign rob.rd_out_a    = rd_q[head_q];
   assign rob.rd_out_rob  = head_q;
   assign rob.rd_out_val  = head_val;
   assign q1_hit       = busy_q[rob.q1_rob] & done_q[rob.q1_rob];
   assign q2_hit       = busy_q[rob.q2_rob] & done_q[rob.q2_rob];
   assign rob.q1_ready = q1_fwd | q1_hit;
   assign rob.q2_ready = q2_fwd | q2_hit;
   assign rob.q1_val   = q1_fwd ? rob.cdb_val : q1_hit ? val_q[rob.q1_rob] : '0;
   assign rob.q2_val   = q2_fwd ? rob.cdb_val : q2_hit ? val_q[rob.q2_rob] : '0;
   always_comb begin
      busy_d   = busy_q;
      done_d   = done_q;
      mis_d    = mis_q;
      has_rd_d = has_rd_q;
      rd_d     = rd_q;
      val_d    = val_q;
      tgt_d    = tgt_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q + 5'(issue_fire) - 5'(commit_fire);
      if (cdb_wr) begin
         done_d[rob.cdb_rob] = 1'b1;
         val_d[rob.cdb_rob]  = rob.cdb_val;
         mis_d[rob.cdb_rob]  = rob.cdb_mispred;
         tgt_d[rob.cdb_rob]  = rob.cdb_target;
      end
      if (commit_fire) begin
         busy_d[head_q] = 1'b0;
         head_d         = head_q + 4'd1;
      end
      if (issue_fire) begin
         busy_d[tail_q]   = 1'b1;
         done_d[tail_q]   = 1'b0;
         mis_d[tail_q]    = 1'b0;
         has_rd_d[tail_q] = rob.issue_has_rd;
         rd_d[tail_q]     = rob.issue_rd;
         tail_d           = tail_q + 4'd1;
      end
      if (rob.flush) begin
         busy_d  = '0;
         done_d  = '0;
         mis_d   = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         done_q  <= '0;
         mis_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         mis_q   <= mis_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   // payload fields are only meaningful while busy, so they need no reset
   always_ff @(posedge clk) begin
      has_rd_q <= has_rd_d;
      rd_q     <= rd_d;
      val_q    <= val_d;
      tgt_q    <= tgt_d;
   end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: random and directed stimulus against a program-order queue model with a commit scoreboard
module tb_rob_commit;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   rob_commit_if ifc ();
   rob_commit dut (.clk(clk), .rst_n(rst_n), .rob(ifc.slave));
`ifdef ROB_CDB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   typedef struct {
      int          tag;
      bit          has_rd;
      int          rd;
      bit          done;
      int unsigned val;
      bit          mis;
      int unsigned tgt;
   } ent_t;
   typedef struct {
      longint      t;
      int          tag;
      bit          has_rd;
      int          rd;
      int unsigned val;
      bit          fl;
      int unsigned pc;
   } exp_t;
   ent_t m[$];
   exp_t sb[$];
   int   tail_tag = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, req, $time);
      end
   endtask

   function automatic int find(input int t);
      foreach (m[i]) if (m[i].tag == t) return i;
      return -1;
   endfunction

   task automatic qchk(input string nm, input int q, input bit cv, input int crob,
                       input int unsigned cval, input logic r, input logic [31:0] v);
      int i;
      bit er;
      int unsigned ev;
      i  = find(q);
      er = 1'b0;
      ev = 0;
      if (i >= 0 && FWD && cv && crob == q) begin
         er = 1'b1;
         ev = cval;
      end else if (i >= 0 && m[i].done) begin
         er = 1'b1;
         ev = m[i].val;
      end
      chk({nm, "_ready"}, r, er);
      chk({nm, "_val"}, v, ev);
   endtask

   task automatic step(input bit rdy, input bit iv, input bit hrd, input int rd, input bit cv,
                       input int crob, input int unsigned cval, input bit cmis,
                       input int unsigned ctgt, input int q1, input int q2);
      int n, ci;
      bit commit, fl, fire;
      int unsigned hv, ht;
      longint t0;
      @(negedge clk);
      t0 = $time;
      ifc.rdy          = rdy;
      ifc.issue_valid  = iv;
      ifc.issue_has_rd = hrd;
      ifc.issue_rd     = 5'(rd);
      ifc.cdb_valid    = cv;
      ifc.cdb_rob      = 4'(crob);
      ifc.cdb_val      = cval;
      ifc.cdb_mispred  = cmis;
      ifc.cdb_target   = ctgt;
      ifc.q1_rob       = 4'(q1);
      ifc.q2_rob       = 4'(q2);
      #1;
      n      = m.size();
      ci     = find(crob);
      commit = rdy && n > 0 && (m[0].done || (FWD && cv && crob == m[0].tag));
      hv     = 0;
      ht     = 0;
      fl     = 1'b0;
      if (commit) begin
         hv = m[0].done ? m[0].val : cval;
         ht = m[0].done ? m[0].tgt : ctgt;
         fl = m[0].done ? m[0].mis : cmis;
      end
      fire = rdy && iv && n < 16 && !fl;
      chk("issue_ready", ifc.issue_ready, n < 16);
      chk("issue_tag", ifc.issue_tag, tail_tag);
      chk("rd_in_rob", ifc.rd_in_rob, tail_tag);
      chk("rd_in_flag", ifc.rd_in_flag, fire && hrd);
      if (fire && hrd) chk("rd_in_a", ifc.rd_in_a, rd);
      qchk("q1", q1, cv, crob, cval, ifc.q1_ready, ifc.q1_val);
      qchk("q2", q2, cv, crob, cval, ifc.q2_ready, ifc.q2_val);
      if (commit && (m[0].has_rd || fl)) sb.push_back('{t0, m[0].tag, m[0].has_rd, m[0].rd, hv, fl, ht});
      if (fl) begin
         m.delete();
         tail_tag = 0;
      end else begin
         if (rdy && cv && ci >= 0) begin
            m[ci].done = 1'b1;
            m[ci].val  = cval;
            m[ci].mis  = cmis;
            m[ci].tgt  = ctgt;
         end
         if (commit) void'(m.pop_front());
         if (fire) begin
            m.push_back('{tail_tag, hrd, rd, 1'b0, 0, 1'b0, 0});
            tail_tag = (tail_tag + 1) % 16;
         end
      end
   endtask

   task automatic issue(input bit hrd, input int rd);
      step(1, 1, hrd, rd, 0, 0, 0, 0, 0, $urandom % 16, $urandom % 16);
   endtask
   task automatic cdb(input int tag, input int unsigned val, input bit mis, input int unsigned tgt);
      step(1, 0, 0, 0, 1, tag, val, mis, tgt, $urandom % 16, $urandom % 16);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, $urandom % 16, $urandom % 16);
   endtask
   task automatic drain();
      int k;
      for (int g = 0; g < 100 && m.size() > 0; g++) begin
         k = -1;
         foreach (m[i]) if (k < 0 && !m[i].done) k = i;
         if (k >= 0) cdb(m[k].tag, $urandom, 1'b0, 0);
         else idle(1);
      end
      idle(2);
      chk("drained", m.size(), 0);
   endtask
   task automatic do_reset(input int n);
      @(negedge clk);
      #3 rst_n = 1'b0;
      m.delete();
      tail_tag = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ifc.rdy = 1'b1;
         ifc.issue_valid = 1'b1;
         ifc.issue_has_rd = 1'b1;
         #1;
         chk("rst_issue_ready", ifc.issue_ready, 1);
         chk("rst_issue_tag", ifc.issue_tag, 0);
         chk("rst_rd_in_flag", ifc.rd_in_flag, 0);
         chk("rst_rd_out_flag", ifc.rd_out_flag, 0);
         chk("rst_flush", ifc.flush, 0);
      end
      @(negedge clk);
      ifc.issue_valid = 1'b0;
      ifc.cdb_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1 && (ifc.rd_out_flag !== 1'b0 || ifc.flush !== 1'b0)) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit rd_out_flag=%b flush=%b want none at %0t",
                        ifc.rd_out_flag, ifc.flush, $time);
            end else begin
               e = sb.pop_front();
               chk("commit_time", $time - 2, e.t);
               chk("rd_out_rob", ifc.rd_out_rob, e.tag);
               chk("rd_out_flag", ifc.rd_out_flag, e.has_rd);
               if (e.has_rd) begin
                  chk("rd_out_a", ifc.rd_out_a, e.rd);
                  chk("rd_out_val", ifc.rd_out_val, e.val);
               end
               chk("flush", ifc.flush, e.fl);
               if (e.fl) chk("flush_pc", ifc.flush_pc, e.pc);
            end
         end
      end
   end

   initial begin
      int k, t;
      int cand[$];
      ifc.rdy = 0; ifc.issue_valid = 0; ifc.issue_has_rd = 0; ifc.issue_rd = 0;
      ifc.cdb_valid = 0; ifc.cdb_rob = 0; ifc.cdb_val = 0; ifc.cdb_mispred = 0;
      ifc.cdb_target = 0; ifc.q1_rob = 0; ifc.q2_rob = 0;
      rst_n = 1'b0;
      do_reset(2);
      issue(1, 5);
      cdb(0, 32'h1234, 0, 0);
      idle(2);
      issue(1, 1); issue(1, 2); issue(1, 3);
      cdb(3, 32'h22, 0, 0);
      cdb(2, 32'h11, 0, 0);
      idle(2);
      cdb(1, 32'h00, 0, 0);
      idle(4);
      for (int i = 0; i < 17; i++) issue(1, i);
      chk("full_count", m.size(), 16);
      cdb(m[0].tag, 32'hbeef, 0, 0);
      idle(2);
      issue(0, 0);
      drain();
      do_reset(1);
      issue(0, 0);
      issue(1, 7);
      cdb(0, 0, 1, 32'h80);
      idle(2);
      chk("flush_empty", m.size(), 0);
      issue(1, 9);
      step(0, 1, 1, 4, 1, 0, 32'h55, 0, 0, 0, 1);
      step(0, 1, 1, 4, 1, 0, 32'h55, 0, 0, 0, 1);
      issue(1, 1); issue(1, 2); issue(1, 3);
      step(1, 0, 0, 0, 1, 3, 32'hab, 0, 0, 3, 2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
      drain();
      for (int c = 0; c < 2000; c++) begin
         if (c == 1000) do_reset(2);
         cand.delete();
         foreach (m[i]) if (!m[i].done) cand.push_back(m[i].tag);
         if (cand.size() > 0 && $urandom % 100 < 85) k = cand[$urandom % cand.size()];
         else begin
            k = $urandom % 16;
            t = find(k);
            if (t >= 0 && m[t].done) k = cand.size() > 0 ? cand[0] : k;
         end
         t = find(k);
         step($urandom % 10 != 0, $urandom % 100 < 60, $urandom % 4 != 0, $urandom % 32,
              $urandom % 100 < 55 && !(t >= 0 && m[t].done), k, $urandom,
              $urandom % 100 < 8, $urandom, $urandom % 16, $urandom % 16);
      end
      drain();
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
